// File: rtl/rules_grid_seq.sv
// Rule-grid firing-strength sequencer: captures one frame of T and dT memberships and
// streams tnorm(muT[i], muD[j]) for every (i, j) in row-major order, with a running sum.
module rules_grid_seq #(
    parameter int NT = 2,
    parameter int ND = 2,
    parameter int W  = 16,
    parameter int SW = W + $clog2(NT * ND) + 1,
    localparam int ITW = (NT > 1) ? $clog2(NT) : 1,
    localparam int IDW = (ND > 1) ? $clog2(ND) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [NT*W-1:0]   muT,
    input  logic [ND*W-1:0]   muD,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [W-1:0]      w_data,
    output logic [ITW-1:0]    w_it,
    output logic [IDW-1:0]    w_id,
    output logic              w_last,
    output logic [SW-1:0]     w_sum
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [W-1:0]   ONE    = {1'b1, {(W-1){1'b0}}};
    localparam logic [ITW-1:0] IT_INC = ITW'(1);
    localparam logic [IDW-1:0] ID_INC = IDW'(1);

    state_t            state, state_nx;
    logic [NT*W-1:0]   mut_p0;
    logic [ND*W-1:0]   mud_p0;
    logic              mode_p0;

    logic [NT*W-1:0]   mut_cl;
    logic [ND*W-1:0]   mud_cl;
    logic [ITW-1:0]    it_nx;
    logic [IDW-1:0]    id_nx;
    logic              load;
    logic              fire;
    logic              accept;
    logic [W-1:0]      opa, opb;
    logic              opm;
    logic [W-1:0]      wt_nx;
    logic [SW-1:0]     sum_nx;
    logic              last_nx;

    function automatic logic [W-1:0] clamp_mu(input logic [W-1:0] x);
        return (x > ONE) ? ONE : x;
    endfunction

    // Both operands are <= 1.0, so the product shifted by W-1 always fits in W bits.
    function automatic logic [W-1:0] tnorm(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic md);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (md)
            return prod[2*W-2 -: W];
        else
            return (a < b) ? a : b;
    endfunction

    always_comb begin
        mut_cl = '0;
        mud_cl = '0;
        for (int k = 0; k < NT; k++) mut_cl[k*W +: W] = clamp_mu(muT[k*W +: W]);
        for (int k = 0; k < ND; k++) mud_cl[k*W +: W] = clamp_mu(muD[k*W +: W]);
    end

    assign in_ready = (state == IDLE);
    assign accept   = (state == IDLE) && in_valid;
    assign fire     = w_valid && w_ready;

    always_comb begin
        state_nx = state;
        it_nx    = w_it;
        id_nx    = w_id;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = RUN;
                    it_nx    = '0;
                    id_nx    = '0;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (fire) begin
                    if (w_last) begin
                        state_nx = IDLE;
                    end else begin
                        load = 1'b1;
                        if (int'(w_id) == ND - 1) begin
                            id_nx = '0;
                            it_nx = w_it + IT_INC;
                        end else begin
                            id_nx = w_id + ID_INC;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The first beat is computed straight from the incoming frame so it lands one cycle after accept.
    always_comb begin
        opa     = (state == IDLE) ? mut_cl[W-1:0] : mut_p0[int'(it_nx)*W +: W];
        opb     = (state == IDLE) ? mud_cl[W-1:0] : mud_p0[int'(id_nx)*W +: W];
        opm     = (state == IDLE) ? mode : mode_p0;
        wt_nx   = tnorm(opa, opb, opm);
        sum_nx  = ((state == IDLE) ? '0 : w_sum) + {{(SW-W){1'b0}}, wt_nx};
        last_nx = (int'(it_nx) == NT - 1) && (int'(id_nx) == ND - 1);
    end

    // Stage p0: frame capture and beat register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mut_p0  <= '0;
            mud_p0  <= '0;
            mode_p0 <= 1'b0;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_it    <= '0;
            w_id    <= '0;
            w_last  <= 1'b0;
            w_sum   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mut_p0  <= mut_cl;
                mud_p0  <= mud_cl;
                mode_p0 <= mode;
            end
            if (load) begin
                w_valid <= 1'b1;
                w_data  <= wt_nx;
                w_it    <= it_nx;
                w_id    <= id_nx;
                w_last  <= last_nx;
                w_sum   <= sum_nx;
            end else if (fire) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rules_grid_seq.md
Name: rules_grid_seq

Overview:
- Parametrised successor of the 4-corner rule evaluator.
- Evaluates the full NT x ND rule grid of firing strengths w[i][j] = tnorm(muT[i], muD[j]) from one captured set of Q1.15 memberships.
- Emits one weight per beat on a valid/ready stream, row-major, with rule indices, a last flag and a running sum for downstream normalisation.
- Sits between the fuzzifiers and the aggregation/defuzzification stage; supports min or product t-norm, selected per frame.

Parameters:
- NT, 2, number of T membership functions (>=1)
- ND, 2, number of dT membership functions (>=1)
- W, 16, membership/weight width (Q1.15 when 16)
- SW, W+$clog2(NT*ND)+1, width of weight sum output

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  membership frame valid
- in_ready  out  1  block can accept a frame
- mode  in  1  t-norm: 0=min, 1=product; sampled with the frame
- muT  in  NT*W  T memberships, index i at bits [i*W +: W]
- muD  in  ND*W  dT memberships, index j at bits [j*W +: W]
- w_valid  out  1  weight beat valid
- w_ready  in  1  downstream accepts beat
- w_data  out  W  rule weight
- w_it  out  max(1,$clog2(NT))  T index i of current beat
- w_id  out  max(1,$clog2(ND))  dT index j of current beat
- w_last  out  1  high on beat (NT-1, ND-1)
- w_sum  out  SW  sum of all weights of the frame up to and including current beat

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=1; w_valid=0; w_data=0; w_it=0; w_id=0; w_last=0; w_sum=0; capture registers cleared.
- FSM states: IDLE, RUN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture muT, muD and mode; clamp each mu above 1.0 (2^(W-1), 0x8000 for W=16) to 1.0; go to RUN.
  - First beat (0,0) is presented with w_valid=1 on the next cycle (latency 1).
- RUN:
  - in_ready=0; in_valid is ignored.
  - Beat held stable (w_data, w_it, w_id, w_last, w_sum) while w_valid && !w_ready.
  - On w_valid&&w_ready with w_last=0: advance j; on j==ND-1 wrap j to 0 and increment i. The next beat is valid on the following cycle, so there are no bubbles while w_ready stays high.
  - On w_valid&&w_ready with w_last=1: next cycle w_valid=0 and state IDLE (in_ready=1). A new frame can be accepted that cycle; minimum frame period is NT*ND+1 cycles.
- Arithmetic (operands unsigned, both <=1.0 after clamp):
  - mode 0: w = min(a,b).
  - mode 1: w = (a*b) >> (W-1), truncation. Full 2W-bit product; result <=1.0, no saturation needed.
- w_sum:
  - Zero-extended accumulation; reset to the first weight at beat (0,0).
  - Updated combinationally per beat index, registered with the beat.
  - Never wraps: SW covers NT*ND*1.0.
- Degenerate sizes: NT=1 or ND=1 is legal; index ports stay 1 bit and hold 0 on the singleton axis. NT=ND=1 gives a single beat with w_last=1.
- Mid-frame reset: the frame is abandoned, outputs return to reset values immediately, and there is no residual beat after release.
- mode or mu changes during RUN have no effect on the current frame.

Test Plan:
- Reset, W=16, NT=ND=2, mode=0, muT={0x2000,0x6000}, muD={0x4000,0x1000}: beats in row-major order (i,j), i.e. (0,0),(0,1),(1,0),(1,1) = 0x2000,0x1000,0x4000,0x1000. w_last only on the 4th beat. Final w_sum=0x8000. First w_valid exactly 1 cycle after accept.
- Same frame, mode=1: (0,0) = 0x2000*0x4000>>15 = 0x1000; (1,1) = 0x6000*0x1000>>15 = 0x0C00. Frame muT={0x8000}, muD={0x8000} with NT=ND=1 gives 0x8000, w_last=1, w_sum=0x8000.
- Backpressure: hold w_ready=0 for 5 cycles on beat (0,1). All beat outputs stay stable, the index does not advance, and in_ready stays 0. Release: remaining beats follow on consecutive cycles.
- Clamp and edge: muT input 0xFFFF is treated as 0x8000. NT=3, ND=2, all mu=0x8000, mode=0: 6 beats of 0x8000, final w_sum=0x30000 with no overflow.
- Back-to-back: in_valid held high with w_ready=1. The second frame is accepted the cycle after the first w_last handshake. Its mode is captured independently of the first frame.
- Async reset asserted mid-frame at beat (1,0): w_valid, w_sum and w_last drop to 0 without a clock edge. After release in_ready=1 and no stale beats appear.
